// File: rtl/shift_piso_tx.sv
// ----------------------------------------------------------------------------
// shift_piso_tx
//
// Parallel-in / serial-out transmitter with a one-word holding register.
// A word taken on the load handshake is shifted out LSB first, one bit per
// clock. While a word is shifting, one further word can be parked in the
// holding register. It then follows the current word with no idle gap.
//
// Parameters
//   N           data word width in bits (N >= 2)
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   reset_n     asynchronous, active-low reset
//   d_in        parallel word to serialize
//   load_valid  d_in holds a word to send
//   load_ready  block can accept a word this cycle
//   s_out       serial data bit, LSB first
//   s_valid     s_out carries a live data bit
//   s_first     current bit is bit 0 of a word
//   word_done   current bit is bit N-1 of a word (one-cycle pulse)
// ----------------------------------------------------------------------------
module shift_piso_tx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] d_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         s_out,
    output logic         s_valid,
    output logic         s_first,
    output logic         word_done
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state,     state_nxt;
    logic [N-1:0]  sreg,      sreg_nxt;
    logic [CW-1:0] cnt,       cnt_nxt;
    logic [N-1:0]  hold,      hold_nxt;
    logic          hold_full, hold_full_nxt;

    logic          accept;

    // The handshake depends only on the holding register. A word is accepted
    // even while the last bit of the current word is shifting out.
    assign accept = load_valid & ~hold_full;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = d_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt != LAST) begin
                    sreg_nxt = sreg >> 1;
                    cnt_nxt  = cnt + CW'(1);
                    if (accept) begin
                        hold_nxt      = d_in;
                        hold_full_nxt = 1'b1;
                    end
                end else if (hold_full) begin
                    // The parked word follows on the very next bit slot.
                    sreg_nxt      = hold;
                    hold_full_nxt = 1'b0;
                    cnt_nxt       = '0;
                end else if (accept) begin
                    // Hold is empty and a word arrives on the last bit.
                    // Load it straight into the shifter so no gap appears.
                    sreg_nxt = d_in;
                    cnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the pre-edge values of the others.
    // NOTE: all state, including the data registers, is reset. A reset
    // mid-word therefore leaves nothing behind that could leak out later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
        end
    end

    assign load_ready = ~hold_full;
    assign s_valid    = (state == SHIFT);
    assign s_out      = s_valid & sreg[0];
    assign s_first    = s_valid && (cnt == '0);
    assign word_done  = s_valid && (cnt == LAST);

endmodule

// File: tb/tb_shift_piso_tx.sv
// ----------------------------------------------------------------------------
// tb_shift_piso_tx
//
// Directed bench for shift_piso_tx with N = 4. Inputs change 1 time unit
// after a rising edge, and outputs are compared at that same point. Cycle k
// of a scenario is the clock period that follows accept edge k-1. A small
// monitor rebuilds serialized words so that word order and word count can
// be compared against the offered words.
// ----------------------------------------------------------------------------
module tb_shift_piso_tx;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] d_in;
    logic         load_valid;
    logic         load_ready;
    logic         s_out;
    logic         s_valid;
    logic         s_first;
    logic         word_done;

    int checks = 0;
    int errors = 0;

    shift_piso_tx #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_in       (d_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .s_out      (s_out),
        .s_valid    (s_valid),
        .s_first    (s_first),
        .word_done  (word_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word monitor: gathers bits while s_valid is high and stores each
    // completed word.
    logic [N-1:0] mon_word = '0;
    int           mon_idx  = 0;
    logic [N-1:0] mon_q[$];

    always @(posedge clk) begin
        if (reset_n && s_valid) begin
            automatic logic [N-1:0] w = mon_word;
            automatic int           i = s_first ? 0 : mon_idx;
            if (i < N) w[i] = s_out;
            mon_word <= w;
            mon_idx  <= i + 1;
            if (word_done) mon_q.push_back(w);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all five outputs at the current cycle.
    task automatic exp_c(input string tag, input logic v, input logic o,
                         input logic f, input logic d, input logic r);
        check({tag, ".s_valid"},    32'(s_valid),    32'(v));
        check({tag, ".s_out"},      32'(s_out),      32'(o));
        check({tag, ".s_first"},    32'(s_first),    32'(f));
        check({tag, ".word_done"},  32'(word_done),  32'(d));
        check({tag, ".load_ready"}, 32'(load_ready), 32'(r));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] words [3] = '{4'h9, 4'h2, 4'hE};
    logic         acc;

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        d_in       = '0;

        // Values presented while reset is held.
        #2;
        exp_c("reset", 0, 0, 0, 0, 1);
        #10;
        reset_n = 1'b1;
        step();
        exp_c("idle0", 0, 0, 0, 0, 1);
        // With load_valid low, d_in is ignored.
        d_in = 4'hF;
        step();
        exp_c("idle_ign", 0, 0, 0, 0, 1);

        // Single word 4'b1011: bits 1,1,0,1 on cycles 1-4.
        d_in = 4'b1011; load_valid = 1'b1;
        step(); load_valid = 1'b0; d_in = '0;
        exp_c("single.c1", 1, 1, 1, 0, 1); step();
        exp_c("single.c2", 1, 1, 0, 0, 1); step();
        exp_c("single.c3", 1, 0, 0, 0, 1); step();
        exp_c("single.c4", 1, 1, 0, 1, 1); step();
        exp_c("single.c5", 0, 0, 0, 0, 1);

        // Back-to-back through hold: 4'hA, then 4'h5 offered from cycle 1.
        d_in = 4'hA; load_valid = 1'b1;
        step(); d_in = 4'h5;
        exp_c("b2b.c1", 1, 0, 1, 0, 1); step(); load_valid = 1'b0; d_in = '0;
        exp_c("b2b.c2", 1, 1, 0, 0, 0); step();
        exp_c("b2b.c3", 1, 0, 0, 0, 0); step();
        exp_c("b2b.c4", 1, 1, 0, 1, 0); step();
        exp_c("b2b.c5", 1, 1, 1, 0, 1); step();
        exp_c("b2b.c6", 1, 0, 0, 0, 1); step();
        exp_c("b2b.c7", 1, 1, 0, 0, 1); step();
        exp_c("b2b.c8", 1, 0, 0, 1, 1); step();
        exp_c("b2b.c9", 0, 0, 0, 0, 1);

        // Bypass: 4'h3, then 4'hC offered only on the last bit of 4'h3.
        d_in = 4'h3; load_valid = 1'b1;
        step(); load_valid = 1'b0; d_in = '0;
        exp_c("byp.c1", 1, 1, 1, 0, 1); step();
        exp_c("byp.c2", 1, 1, 0, 0, 1); step();
        exp_c("byp.c3", 1, 0, 0, 0, 1); step();
        exp_c("byp.c4", 1, 0, 0, 1, 1);
        d_in = 4'hC; load_valid = 1'b1;
        step(); load_valid = 1'b0; d_in = '0;
        exp_c("byp.c5", 1, 0, 1, 0, 1); step();
        exp_c("byp.c6", 1, 0, 0, 0, 1); step();
        exp_c("byp.c7", 1, 1, 0, 0, 1); step();
        exp_c("byp.c8", 1, 1, 0, 1, 1); step();
        exp_c("byp.c9", 0, 0, 0, 0, 1);

        // Reset during cycle 2 of 4'hF with 4'h6 parked in hold.
        mon_q.delete();
        d_in = 4'hF; load_valid = 1'b1;
        step(); d_in = 4'h6;
        exp_c("rst.c1", 1, 1, 1, 0, 1); step(); load_valid = 1'b0; d_in = '0;
        exp_c("rst.c2", 1, 1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        exp_c("rst.async", 0, 0, 0, 0, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_c($sformatf("rst.after%0d", k), 0, 0, 0, 0, 1);
        end
        check("rst.no_words", 32'(mon_q.size()), 32'd0);

        // Stall: words held valid until accepted, with random gaps.
        mon_q.delete();
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 2)) step();
            d_in = words[k]; load_valid = 1'b1;
            acc  = 1'b0;
            for (int b = 0; b < 20; b++) begin
                @(negedge clk);
                acc = load_ready;
                @(posedge clk);
                #1;
                if (acc) break;
            end
            load_valid = 1'b0; d_in = '0;
            check($sformatf("stall.accept%0d", k), 32'(acc), 32'd1);
        end
        for (int b = 0; b < 40 && mon_q.size() < 3; b++) step();
        repeat (8) step();
        check("stall.count", 32'(mon_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall.word%0d", k),
                  32'((k < mon_q.size()) ? mon_q[k] : 4'hx), 32'(words[k]));
        end
        exp_c("stall.idle", 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
